// File: rtl/match_controller.sv
// Match-level sequencer for the ping-pong game: scores, serve order, post-point pause,
// win detection and ball speed (tick period) control.
module match_controller #(
   parameter int unsigned WIN_SCORE      = 5,
   parameter int unsigned PAUSE_CYCLES   = 200_000_000,
   parameter int unsigned INIT_PERIOD    = 25_000_000,
   parameter int unsigned MIN_PERIOD     = 5_000_000,
   parameter int unsigned PERIOD_STEP    = 2_500_000,
   parameter int unsigned HITS_PER_LEVEL = 4,
   parameter int unsigned PW             = 25
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          hit,
   input  logic          p1_point,
   input  logic          p2_point,
   output logic          serve_go,
   output logic          serve_side,
   output logic          play_en,
   output logic [PW-1:0] step_period,
   output logic [3:0]    p1_score,
   output logic [3:0]    p2_score,
   output logic          game_over,
   output logic          winner
);

   localparam int unsigned HIT_W   = $clog2(HITS_PER_LEVEL + 1);
   localparam int unsigned PAUSE_W = $clog2(PAUSE_CYCLES + 1);

   localparam logic [PW-1:0]    INIT_P    = PW'(INIT_PERIOD);
   localparam logic [PW-1:0]    MIN_P     = PW'(MIN_PERIOD);
   localparam logic [PW-1:0]    STEP_P    = PW'(PERIOD_STEP);
   localparam logic [PW:0]      FLOOR_SUM = (PW+1)'(MIN_PERIOD) + (PW+1)'(PERIOD_STEP);
   localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
   localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
   localparam logic [3:0]       WIN_S     = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      StIdle, StServe, StRally, StPointPause, StGameOver
   } state_e;

   state_e             state;
   logic               start_q;
   logic               start_edge;
   logic [HIT_W-1:0]   hit_cnt;
   logic [PAUSE_W-1:0] pause_cnt;
   logic [3:0]         p1_next;
   logic [3:0]         p2_next;

   assign start_edge = start & ~start_q;
   assign p1_next    = p1_score + 4'd1;
   assign p2_next    = p2_score + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         start_q     <= 1'b0;
         serve_go    <= 1'b0;
         serve_side  <= 1'b0;
         play_en     <= 1'b0;
         step_period <= INIT_P;
         p1_score    <= 4'd0;
         p2_score    <= 4'd0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
         hit_cnt     <= '0;
         pause_cnt   <= '0;
      end else begin
         start_q  <= start;
         serve_go <= 1'b0;
         unique case (state)
            StIdle, StGameOver: begin
               if (start_edge) begin
                  p1_score    <= 4'd0;
                  p2_score    <= 4'd0;
                  serve_side  <= 1'b0;
                  step_period <= INIT_P;
                  hit_cnt     <= '0;
                  game_over   <= 1'b0;
                  serve_go    <= 1'b1;
                  state       <= StServe;
               end
            end
            StServe: begin
               play_en <= 1'b1;
               state   <= StRally;
            end
            StRally: begin
               if (p1_point && p2_point) begin
                  // Both players claiming the point is a protocol error: replay it.
                  play_en   <= 1'b0;
                  pause_cnt <= '0;
                  state     <= StPointPause;
               end else if (p1_point || p2_point) begin
                  play_en     <= 1'b0;
                  pause_cnt   <= '0;
                  step_period <= INIT_P;
                  hit_cnt     <= '0;
                  serve_side  <= p1_point;
                  if (p1_point) p1_score <= p1_next;
                  else          p2_score <= p2_next;
                  if ((p1_point && p1_next == WIN_S) || (p2_point && p2_next == WIN_S)) begin
                     game_over <= 1'b1;
                     winner    <= p2_point;
                     state     <= StGameOver;
                  end else begin
                     state <= StPointPause;
                  end
               end else if (hit) begin
                  if (hit_cnt == HIT_LAST) begin
                     hit_cnt <= '0;
                     if ({1'b0, step_period} >= FLOOR_SUM) step_period <= step_period - STEP_P;
                     else                                  step_period <= MIN_P;
                  end else begin
                     hit_cnt <= hit_cnt + HIT_W'(1);
                  end
               end
            end
            StPointPause: begin
               if (pause_cnt == PAUSE_LAST) begin
                  serve_go <= 1'b1;
                  state    <= StServe;
               end else begin
                  pause_cnt <= pause_cnt + PAUSE_W'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed stimulus, a rule-level reference model compared
// every cycle, plus hand-computed literal checks.
module tb_match_controller;

   localparam int WIN = 3, PAUSE = 4, INIT = 20, MINP = 8, STEP = 5, HITS = 2, PW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0, hit = 1'b0, p1_point = 1'b0, p2_point = 1'b0;
   logic          serve_go, serve_side, play_en, game_over, winner;
   logic [PW-1:0] step_period;
   logic [3:0]    p1_score, p2_score;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   match_controller #(
      .WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE), .INIT_PERIOD(INIT), .MIN_PERIOD(MINP),
      .PERIOD_STEP(STEP), .HITS_PER_LEVEL(HITS), .PW(PW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .hit(hit), .p1_point(p1_point),
      .p2_point(p2_point), .serve_go(serve_go), .serve_side(serve_side), .play_en(play_en),
      .step_period(step_period), .p1_score(p1_score), .p2_score(p2_score),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 serve, 2 rally, 3 pause, 4 game over.
   int m_phase, m_p1, m_p2, m_side, m_hits, m_left, m_winner;
   bit m_start_prev, m_edge;

   function automatic int exp_step();
      int v;
      v = INIT - STEP * (m_hits / HITS);
      return (v < MINP) ? MINP : v;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0; m_p1 = 0; m_p2 = 0; m_side = 0; m_hits = 0; m_left = 0;
         m_winner = 0; m_start_prev = 1'b0;
      end else begin
         m_edge = start && !m_start_prev;
         m_start_prev = start;
         case (m_phase)
            0, 4: if (m_edge) begin
               m_p1 = 0; m_p2 = 0; m_side = 0; m_hits = 0; m_phase = 1;
            end
            1: m_phase = 2;
            2: begin
               if (p1_point && p2_point) begin
                  m_phase = 3; m_left = PAUSE;
               end else if (p1_point || p2_point) begin
                  m_hits = 0; m_left = PAUSE;
                  if (p1_point) begin m_p1++; m_side = 1; end
                  else          begin m_p2++; m_side = 0; end
                  if (m_p1 == WIN || m_p2 == WIN) begin
                     m_phase = 4; m_winner = p2_point ? 1 : 0;
                  end else begin
                     m_phase = 3;
                  end
               end else if (hit) begin
                  m_hits++;
               end
            end
            3: begin
               m_left--;
               if (m_left == 0) m_phase = 1;
            end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_serve_go", serve_go, m_phase == 1);
         check("cmp_play_en", play_en, m_phase == 2);
         check("cmp_game_over", game_over, m_phase == 4);
         check("cmp_serve_side", serve_side, m_side);
         check("cmp_step_period", step_period, exp_step());
         check("cmp_p1_score", p1_score, m_p1);
         check("cmp_p2_score", p2_score, m_p2);
         if (m_phase == 4) check("cmp_winner", winner, m_winner);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_serve(output int n);
      n = 0;
      while (serve_go !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("serve_go_within_bound", n < 50, 1);
   endtask

   task automatic pulse_point(input bit p1, input bit p2, input bit h);
      p1_point = p1; p2_point = p2; hit = h;
      tick();
      p1_point = 1'b0; p2_point = 1'b0; hit = 1'b0;
   endtask

   int n;
   int exp_sp[6] = '{20, 15, 15, 10, 10, 8};

   initial begin
      tick(); tick();
      chk_en = 1'b1;
      check("rst_step_period", step_period, 20);
      check("rst_play_en", play_en, 0);
      reset = 1'b0;
      tick();

      // 1: start held high gives a single serve
      start = 1'b1;
      tick();
      check("t1_serve_go", serve_go, 1);
      check("t1_serve_side", serve_side, 0);
      tick();
      check("t1_play_en", play_en, 1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (serve_go === 1'b1) n++;
      end
      check("t1_no_second_serve", n, 0);
      start = 1'b0;

      // 2: speed-up on every second hit, clamped at MIN
      for (int i = 0; i < 6; i++) begin
         hit = 1'b1; tick(); hit = 1'b0;
         check($sformatf("t2_step_after_hit%0d", i + 1), step_period, exp_sp[i]);
         tick();
      end

      // 3: P2 scores, pause, reserve
      pulse_point(1'b0, 1'b1, 1'b0);
      check("t3_p2_score", p2_score, 1);
      check("t3_play_en", play_en, 0);
      check("t3_serve_side", serve_side, 0);
      check("t3_step_reset", step_period, 20);
      wait_serve(n);
      check("t3_pause_len", n, 4);
      tick();

      // 4: P1 wins 3-1
      for (int k = 0; k < 3; k++) begin
         pulse_point(1'b1, 1'b0, 1'b0);
         if (k < 2) begin
            wait_serve(n);
            tick();
         end
      end
      check("t4_game_over", game_over, 1);
      check("t4_winner", winner, 0);
      check("t4_p1_score", p1_score, 3);
      pulse_point(1'b0, 1'b1, 1'b0);
      tick();
      check("t4_p2_ignored", p2_score, 1);
      start = 1'b1;
      tick();
      check("t4_restart_serve", serve_go, 1);
      check("t4_restart_p1", p1_score, 0);
      check("t4_restart_over", game_over, 0);
      tick();
      start = 1'b0;

      // 5: double point, then hit coinciding with a point
      pulse_point(1'b1, 1'b1, 1'b0);
      check("t5_dbl_p1", p1_score, 0);
      check("t5_dbl_p2", p2_score, 0);
      check("t5_dbl_side", serve_side, 0);
      wait_serve(n);
      tick();
      hit = 1'b1; tick(); hit = 1'b0;
      pulse_point(1'b1, 1'b0, 1'b1);
      check("t5_hitpt_p1", p1_score, 1);
      check("t5_hitpt_step", step_period, 20);
      check("t5_hitpt_side", serve_side, 1);
      wait_serve(n);
      tick();
      hit = 1'b1; tick(); hit = 1'b0;
      check("t5_first_hit_no_speedup", step_period, 20);
      hit = 1'b1; tick(); hit = 1'b0;
      check("t5_second_hit_speedup", step_period, 15);

      // 6: reset mid-rally and mid-pause
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6a_play_en", play_en, 0);
      check("t6a_score", p1_score, 0);
      check("t6a_step", step_period, 20);
      check("t6a_side", serve_side, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (serve_go === 1'b1) n++;
      end
      check("t6a_no_serve", n, 0);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      pulse_point(1'b1, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6b_p1_score", p1_score, 0);
      check("t6b_serve_go", serve_go, 0);
      check("t6b_game_over", game_over, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (serve_go === 1'b1) n++;
      end
      check("t6b_no_serve", n, 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
